// File: rtl/com_to_in.sv
// Oversampled UART-style receiver: start, 8 data bits LSB first, even parity, stop.
// Samples the synchronized line once per bit at mid-period and reports errors per frame.
module com_to_in #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       rx,
  output logic [7:0] data,
  output logic       isValid,
  output logic       parityErr,
  output logic       frameErr,
  output logic       isBusy
);

  localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BRK    = 3'd5
  } state_t;

  function automatic logic even_parity8(input logic [7:0] v);
    even_parity8 = ^v;
  endfunction

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            par_q;
  logic            rx_meta_q;
  logic            rx_sync_q;
  logic            sample_s;

  // Two-flop synchronizer for the asynchronous serial line, runs every clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Mid-bit sample strobe: half a period after t0 for start, full periods afterwards.
  always_comb begin
    sample_s = 1'b0;
    case (state_q)
      ST_START:                     sample_s = enable && (cnt_q == HALF_M1);
      ST_DATA, ST_PARITY, ST_STOP:  sample_s = enable && (cnt_q == FULL_M1);
      default:                      sample_s = 1'b0;
    endcase
  end

  // Tick counter next value; restarts at t0 and after every sample, frozen without enable.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable) begin
      cnt_d = cnt_q;
    end else if (state_q == ST_IDLE || state_q == ST_BRK || sample_s) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Receiver state machine with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CW{1'b0}};
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
      data      <= 8'h00;
      isValid   <= 1'b0;
      parityErr <= 1'b0;
      frameErr  <= 1'b0;
      isBusy    <= 1'b0;
    end else begin
      isValid <= 1'b0;
      cnt_q   <= cnt_d;
      if (enable) begin
        case (state_q)
          ST_IDLE: begin
            if (!rx_sync_q) begin
              state_q <= ST_START;
              isBusy  <= 1'b1;
            end
          end
          ST_START: begin
            if (sample_s) begin
              if (rx_sync_q) begin
                state_q <= ST_IDLE;
                isBusy  <= 1'b0;
              end else begin
                state_q   <= ST_DATA;
                bit_idx_q <= 3'd0;
              end
            end
          end
          ST_DATA: begin
            if (sample_s) begin
              shift_q <= {rx_sync_q, shift_q[7:1]};
              if (bit_idx_q == 3'd7) begin
                state_q   <= ST_PARITY;
                bit_idx_q <= 3'd0;
              end else begin
                bit_idx_q <= bit_idx_q + 3'd1;
              end
            end
          end
          ST_PARITY: begin
            if (sample_s) begin
              par_q   <= rx_sync_q;
              state_q <= ST_STOP;
            end
          end
          ST_STOP: begin
            if (sample_s) begin
              data      <= shift_q;
              isValid   <= 1'b1;
              parityErr <= (par_q != even_parity8(shift_q));
              frameErr  <= ~rx_sync_q;
              if (rx_sync_q) begin
                state_q <= ST_IDLE;
                isBusy  <= 1'b0;
              end else begin
                state_q <= ST_BRK;
              end
            end
          end
          // A held-low line must go high again before another start can be seen.
          ST_BRK: begin
            if (rx_sync_q) begin
              state_q <= ST_IDLE;
              isBusy  <= 1'b0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            isBusy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_com_to_in.sv
// Scoreboard bench for com_to_in: frames are queued when driven and checked on isValid.
module tb_com_to_in;
  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       rx;
  logic [7:0] data;
  logic       isValid;
  logic       parityErr;
  logic       frameErr;
  logic       isBusy;

  int total = 0;
  int bad = 0;
  int vcount = 0;
  bit en_div3 = 1'b0;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;
  exp_t exp_q[$];

  com_to_in #(.OVERSAMPLE(OS)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rx(rx),
    .data(data), .isValid(isValid), .parityErr(parityErr),
    .frameErr(frameErr), .isBusy(isBusy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    int ph;
    ph = 0;
    enable = 1'b1;
    forever begin
      @(negedge clk);
      if (en_div3) begin
        ph = (ph + 1) % 3;
        enable = (ph == 0);
      end else begin
        enable = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Scoreboard checker: every isValid pops one expected frame.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && isValid === 1'b1) begin
        vcount++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_valid: got data=%h, no frame expected", data);
        end else begin
          e = exp_q.pop_front();
          if (data !== e.d) begin
            bad++;
            $display("FAIL sb_data: got %h want %h", data, e.d);
          end
          total++;
          if (parityErr !== e.pe) begin
            bad++;
            $display("FAIL sb_parityErr: got %b want %b (data %h)", parityErr, e.pe, e.d);
          end
          total++;
          if (frameErr !== e.fe) begin
            bad++;
            $display("FAIL sb_frameErr: got %b want %b (data %h)", frameErr, e.fe, e.d);
          end
        end
      end
    end
  end

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (enable) k++;
    end
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    wait_ticks(OS);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
    exp_t e;
    e.d = b;
    e.pe = (par != (^b));
    e.fe = ~stp;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(par);
    drive_bit(stp);
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", data); end
    check_bit("reset_isValid", isValid, 1'b0);
    check_bit("reset_parityErr", parityErr, 1'b0);
    check_bit("reset_frameErr", frameErr, 1'b0);
    check_bit("reset_isBusy", isBusy, 1'b0);
    rst_n = 1'b1;
    wait_ticks(10);
  endtask

  task automatic test_basic();
    int v0;
    v0 = vcount;
    send_frame(8'hA5, 1'b0, 1'b1);
    wait_ticks(20);
    total++;
    if (vcount - v0 != 1) begin bad++; $display("FAIL basic_count: got %0d want 1", vcount - v0); end
    total++;
    if (data !== 8'hA5) begin bad++; $display("FAIL basic_hold_data: got %h want a5", data); end
    check_bit("basic_isBusy_after", isBusy, 1'b0);
  endtask

  task automatic test_parity();
    send_frame(8'h01, 1'b0, 1'b1);
    wait_ticks(5);
    check_bit("parity_err_held", parityErr, 1'b1);
    send_frame(8'h03, 1'b0, 1'b1);
    wait_ticks(5);
    check_bit("parity_err_cleared", parityErr, 1'b0);
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL parity_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_break();
    exp_t e;
    int v0;
    v0 = vcount;
    e.d = 8'h3C; e.pe = 1'b0; e.fe = 1'b1;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(e.d[i]);
    drive_bit(1'b0);
    rx = 1'b0;
    wait_ticks(40);
    total++;
    if (vcount - v0 != 1) begin bad++; $display("FAIL break_count: got %0d want 1", vcount - v0); end
    check_bit("break_busy_held", isBusy, 1'b1);
    rx = 1'b1;
    wait_ticks(5);
    check_bit("break_busy_released", isBusy, 1'b0);
    wait_ticks(20);
  endtask

  task automatic test_glitch();
    int v0;
    int busy_ticks;
    v0 = vcount;
    busy_ticks = 0;
    rx = 1'b0;
    for (int k = 0; k < 30; k++) begin
      wait_ticks(1);
      if (k == 3) rx = 1'b1;
      if (isBusy === 1'b1) busy_ticks++;
    end
    total++;
    if (busy_ticks < 1 || busy_ticks > 9) begin
      bad++;
      $display("FAIL glitch_busy_ticks: got %0d want 1..9", busy_ticks);
    end
    check_bit("glitch_busy_low", isBusy, 1'b0);
    total++;
    if (vcount != v0) begin bad++; $display("FAIL glitch_count: got %0d want 0", vcount - v0); end
  endtask

  task automatic test_line_break();
    exp_t e;
    int v0;
    v0 = vcount;
    e.d = 8'h00; e.pe = 1'b0; e.fe = 1'b1;
    exp_q.push_back(e);
    rx = 1'b0;
    wait_ticks(11 * OS + 50);
    total++;
    if (vcount - v0 != 1) begin bad++; $display("FAIL linebreak_count: got %0d want 1", vcount - v0); end
    check_bit("linebreak_busy", isBusy, 1'b1);
    rx = 1'b1;
    wait_ticks(5);
    check_bit("linebreak_idle", isBusy, 1'b0);
    wait_ticks(10);
  endtask

  task automatic test_back_to_back();
    int v0;
    en_div3 = 1'b1;
    wait_ticks(5);
    v0 = vcount;
    send_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b1);
    wait_ticks(20);
    total++;
    if (vcount - v0 != 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", vcount - v0); end
    total++;
    if (data !== 8'hAA) begin bad++; $display("FAIL b2b_data: got %h want aa", data); end
    en_div3 = 1'b0;
    wait_ticks(5);
  endtask

  task automatic test_reset_mid_frame();
    int v0;
    v0 = vcount;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    wait_ticks(OS / 2);
    rst_n = 1'b0;
    #1;
    check_bit("midrst_busy", isBusy, 1'b0);
    total++;
    if (data !== 8'h00) begin bad++; $display("FAIL midrst_data: got %h want 00", data); end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rx = 1'b1;
    wait_ticks(20);
    send_frame(8'h12, 1'b0, 1'b1);
    wait_ticks(20);
    total++;
    if (vcount - v0 != 1) begin bad++; $display("FAIL midrst_count: got %0d want 1", vcount - v0); end
    total++;
    if (data !== 8'h12) begin bad++; $display("FAIL midrst_data_after: got %h want 12", data); end
  endtask

  initial begin
    rst_n = 1'b0;
    rx = 1'b1;
    test_reset();
    test_basic();
    test_parity();
    test_break();
    test_glitch();
    test_line_break();
    test_back_to_back();
    test_reset_mid_frame();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL final_pending: got %0d want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
